imm_extract: RTL

Decode-side pipeline stage that accepts 32-bit RV32 instruction words over a valid/ready handshake. It identifies the immediate format, extracts the raw 12-bit immediate field and presents it, registered, to the downstream sign-extension stage, which takes a 12-bit `imm`. A 2-entry skid buffer gives full throughput under backpressure. A saturating counter tracks accepted instructions that carry no 12-bit immediate.

---
 rtl/imm_extract.sv | 119 +++++++++++
 1 files changed

// File: rtl/imm_extract.sv
// RV32 immediate-field extraction stage: decodes the immediate format and
// presents the raw 12-bit field through a registered output with a one-entry skid.
module imm_extract (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_imm,
  output logic [1:0]  out_fmt,
  output logic [7:0]  illegal_cnt
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 12;
  localparam int unsigned FMT_W   = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(3);

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic [FMT_W-1:0] fmt;
  } entry_t;

  entry_t             dec;
  entry_t             out_q, out_n;
  entry_t             skid_q, skid_n;
  logic               out_valid_n;
  logic               skid_valid, skid_valid_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               accept;
  logic               drain;
  logic               unused_bits;

  // Bits [19:12] (rs1/funct3) never contribute to a 12-bit immediate.
  assign unused_bits = ^in_instr[19:12];

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Format decode and raw field extraction; B yields imm[12:1].
  always_comb begin
    dec.fmt = FMT_NONE;
    dec.imm = '0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.imm = in_instr[INSTR_W-1:20];
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = {in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
      end
      default: begin
        dec.fmt = FMT_NONE;
        dec.imm = '0;
      end
    endcase
  end

  // Output/skid next state; skid always drains before new input reaches the output.
  always_comb begin
    out_n        = out_q;
    out_valid_n  = out_valid;
    skid_n       = skid_q;
    skid_valid_n = skid_valid;
    cnt_n        = illegal_cnt;
    if (!out_valid || drain) begin
      if (skid_valid) begin
        out_n        = skid_q;
        out_valid_n  = 1'b1;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        out_n       = dec;
        out_valid_n = 1'b1;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_n       = dec;
      skid_valid_n = 1'b1;
    end
    if (accept && (dec.fmt == FMT_NONE) && (illegal_cnt != {CNT_W{1'b1}})) begin
      cnt_n = illegal_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid   <= 1'b0;
      skid_q      <= '0;
      skid_valid  <= 1'b0;
      in_ready    <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      out_q       <= out_n;
      out_valid   <= out_valid_n;
      skid_q      <= skid_n;
      skid_valid  <= skid_valid_n;
      in_ready    <= !skid_valid_n;
      illegal_cnt <= cnt_n;
    end
  end

  assign out_imm = out_q.imm;
  assign out_fmt = out_q.fmt;

endmodule
